uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Runtime-configurable 8-bit-bus UART transmitter, the parametrised successor to the fixed 8N1 serial TX peripheral. It supports 5–8 data bits, none/even/odd parity and 1 or 2 stop bits. It adds a transmit-enable gate and a busy flag. It sits behind the peripheral bus as a Wishbone slave (Registered Feedback, Advanced), buffers bytes in a FIFO and serialises them on `tx`.

## Interface
- `BUFFER`, default 32: FIFO depth in bytes; must be a power of two, 2..1024.
- `clk`  in  1  clock.
- `rstz`  in  1  reset, asynchronous, active-low.
- `tx`  out  1  serial line, idles high.
- `prescaler`  in  16  bit period is `prescaler+1` clocks.
- `data_bits`  in  2  data bit count: 0=5, 1=6, 2=7, 3=8.
- `parity`  in  2  parity mode: 0=none, 1=even, 2=odd, 3=none.
- `stop2`  in  1  stop bits: 1 selects two, 0 selects one.
- `enable`  in  1  allows new frames to start.
- `clear`  in  1  synchronous FIFO flush.
- `full`, `empty`  out  1  registered FIFO status.
- `size`  out  16  FIFO occupancy, zero-extended.
- `busy`  out  1  high while a frame is on the line.
- `dat_i`  in  8  write data.
- `we_i`, `stb_i`  in  1  Wishbone write enable and strobe.
- `ack_o`  out  1  Wishbone acknowledge.

## Operation
- Reset values: `tx`=1, `ack_o`=0, `full`=0, `empty`=1, `size`=0, `busy`=0. The FSM resets to IDLE.
- Bus write path:
  - `ack` <= `stb_i & we_i`, and `ack_o = stb_i & ack`.
  - A byte is enqueued on every cycle where `stb_i & we_i & ack` is high.
  - Writes to a full FIFO are acked and the byte is silently dropped.
  - Reads (`we_i`=0) are never acked.
- FSM states are IDLE and TRANSMIT.
- IDLE→TRANSMIT on the init cycle, defined as `enable & ~empty_fifo`. On init:
  - pop one byte;
  - latch `prescaler`, `data_bits`, `parity` and `stop2` into frame registers;
  - reset the bit timer.
- Frame, LSB first: start bit 0, then N data bits `dat[N-1:0]`, then an optional parity bit, then 1 or 2 stop bits of 1.
  - Total bits = 1+N+P+S, where P∈{0,1} and S∈{1,2}.
- Parity bit:
  - even mode sends the XOR of the N data bits;
  - odd mode sends the inverted XOR.
  - Bits above N never affect parity.
- TRANSMIT→IDLE on the final tick of the last stop bit.
- Config inputs changing mid-frame affect only the next frame.
- `enable` low blocks new frames only; an in-flight frame always completes.
- `clear` empties the FIFO in one cycle and does not abort an in-flight frame. If `clear` and a write coincide, `clear` wins.
- An init pop and a bus push in the same cycle are both honoured, so `size` is unchanged.
- `busy` is registered: high from the cycle `tx` falls for the start bit until the cycle after the last stop bit ends.

## Timing
- Bit timer counts 0..`prescaler_l` and ticks at `timer==prescaler_l`. Each bit therefore lasts exactly `prescaler_l+1` clocks.
- `tx` is registered and falls on the clock edge ending the init cycle. Latency from the first write ack to the `tx` falling edge is 3 clocks when `enable`=1 and the line is idle.
- The last stop bit is followed by one IDLE clock with `tx`=1. Back-to-back frames therefore gap by exactly one clock.
- `full` and `empty` lag the FIFO by one clock. `size` comes straight from the FIFO's registered count.
- `prescaler`=0 gives 1 clock per bit, which must work.
- Reset asserted mid-frame forces `tx`=1, IDLE, and an empty FIFO immediately (asynchronously).

## Structure
- Package `uart_pkg`:
  - typedef `parity_e` {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE2};
  - enum `uart_tx_state_e` {IDLE, TRANSMIT};
  - function `data_len(logic [1:0])`, returning 5..8.
- Sub-module: existing `fifo` (WIDTH=8, DEPTH=BUFFER), instantiated as `u_buffer`.
- Shift register is 12 bits (1 start + 8 data + 1 parity + 2 stop), with a one-hot tracker sized to the latched frame length.

## Test plan
- 8N1 with `prescaler`=3, write 0xA5 → `tx` = 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, 40 clocks total; `busy` high throughout.
- 7E2 with `prescaler`=1, write 0xC1 → `tx` = 0,1,0,0,0,0,0,1,0 (parity),1,1 at 2 clocks/bit; bit 7 of the byte is ignored.
- 5O1 with `prescaler`=0, write 0x1F then 0x00:
  - first frame is 0,1,1,1,1,1,0,1;
  - second is 0,0,0,0,0,0,1,1;
  - exactly one idle clock between the frames.
- `enable`=0, write BUFFER+2 bytes → every write acked, `size`=BUFFER, `full`=1, `tx` stays 1; set `enable`=1 → BUFFER frames sent, then `empty`=1.
- Mid-frame `clear` plus a change to `data_bits` and `prescaler` → current frame finishes at the old config, FIFO empties, and a subsequent write uses the new config.
- `rstz` pulse during the data bits of a frame → `tx`=1, `busy`=0, `size`=0 immediately; no residual frame after release.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE  = 2'd0,
        PAR_EVEN  = 2'd1,
        PAR_ODD   = 2'd2,
        PAR_NONE2 = 2'd3
    } parity_e;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } uart_tx_state_e;

    localparam int FRAME_W = 12;

    // Encoded data_bits field to number of data bits on the line (5..8).
    function automatic logic [3:0] data_len(input logic [1:0] code);
        return 4'd5 + {2'b00, code};
    endfunction

endpackage

// File: rtl/uart_tx_cfg_fifo.sv
// Byte FIFO with registered read port, occupancy count and one-clock-lagged flags.
module fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rstz,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             full_reg;
    logic             empty_reg;
    logic             push_ok;
    logic             pop_ok;

    // clear takes priority over both a push and a pop in the same cycle
    assign push_ok = push & ~clear & (count_reg != FULL_COUNT);
    assign pop_ok  = pop  & ~clear & (count_reg != '0);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (clear) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
            end
            full_reg  <= (count_reg == FULL_COUNT);
            empty_reg <= (count_reg == '0);
        end
    end

    // Storage and head read kept reset-free so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_reg] <= din;
        dout_reg <= mem[rd_ptr_reg];
    end

    assign dout  = dout_reg;
    assign count = count_reg;
    assign full  = full_reg;
    assign empty = empty_reg;

endmodule

// File: rtl/uart_tx_cfg.sv
// Wishbone-fed UART transmitter with runtime frame format (5-8 data bits,
// none/even/odd parity, 1 or 2 stop bits) and a bit-rate prescaler.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int BUFFER = 32
) (
    input  logic        clk,
    input  logic        rstz,
    output logic        tx,
    input  logic [15:0] prescaler,
    input  logic [1:0]  data_bits,
    input  logic [1:0]  parity,
    input  logic        stop2,
    input  logic        enable,
    input  logic        clear,
    output logic        full,
    output logic        empty,
    output logic [15:0] size,
    output logic        busy,
    input  logic [7:0]  dat_i,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o
);

    localparam int AW = $clog2(BUFFER);

    logic                ack_reg;
    logic                push;
    logic                init;
    logic [7:0]          fifo_dout;
    logic [AW:0]         fifo_count;
    logic                fifo_empty;

    uart_tx_state_e      state_reg, state_next;
    logic [15:0]         timer_reg, timer_next;
    logic [15:0]         prescaler_reg, prescaler_next;
    logic [FRAME_W-1:0]  shift_reg, shift_next;
    logic [FRAME_W-1:0]  trk_reg, trk_next;
    logic                busy_reg, busy_next;

    logic [FRAME_W-1:0]  frame;
    logic [3:0]          frame_len;
    logic [3:0]          n_bits;
    logic                par_en;
    logic                par_bit;
    logic [7:0]          masked;
    logic                tick;

    // Registered-feedback handshake: ack follows a write strobe by one cycle.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) ack_reg <= 1'b0;
        else       ack_reg <= stb_i & we_i;
    end

    assign ack_o = stb_i & ack_reg;
    assign push  = stb_i & we_i & ack_reg;

    fifo #(
        .WIDTH (8),
        .DEPTH (BUFFER)
    ) u_buffer (
        .clk   (clk),
        .rstz  (rstz),
        .clear (clear),
        .push  (push),
        .pop   (init),
        .din   (dat_i),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (full),
        .empty (fifo_empty)
    );

    assign empty = fifo_empty;
    assign size  = 16'(fifo_count);

    // Whole frame assembled at init; unused upper slots stay 1 so they double as stop/idle.
    always_comb begin
        n_bits  = data_len(data_bits);
        par_en  = (parity_e'(parity) == PAR_EVEN) || (parity_e'(parity) == PAR_ODD);
        masked  = '0;
        frame   = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n_bits)) begin
                masked[i]    = fifo_dout[i];
                frame[i + 1] = fifo_dout[i];
            end
        end
        par_bit = (^masked) ^ (parity_e'(parity) == PAR_ODD);
        if (par_en) frame[n_bits + 4'd1] = par_bit;
        frame_len = 4'd1 + n_bits + {3'b000, par_en} + (stop2 ? 4'd2 : 4'd1);
    end

    assign init = (state_reg == IDLE) & enable & ~fifo_empty & (fifo_count != '0);
    assign tick = (timer_reg == prescaler_reg);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_reg     <= IDLE;
            timer_reg     <= '0;
            prescaler_reg <= '0;
            shift_reg     <= '1;
            trk_reg       <= '0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            timer_reg     <= timer_next;
            prescaler_reg <= prescaler_next;
            shift_reg     <= shift_next;
            trk_reg       <= trk_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        timer_next     = timer_reg;
        prescaler_next = prescaler_reg;
        shift_next     = shift_reg;
        trk_next       = trk_reg;
        busy_next      = busy_reg;
        case (state_reg)
            IDLE: begin
                if (init) begin
                    state_next     = TRANSMIT;
                    timer_next     = '0;
                    prescaler_next = prescaler;
                    shift_next     = frame;
                    trk_next       = 12'd1 << (frame_len - 4'd1);
                    busy_next      = 1'b1;
                end
            end
            TRANSMIT: begin
                if (tick) begin
                    timer_next = '0;
                    shift_next = {1'b1, shift_reg[FRAME_W-1:1]};
                    trk_next   = trk_reg >> 1;
                    // tracker bit 0 marks the last stop bit of this frame
                    if (trk_reg[0]) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end else begin
                    timer_next = timer_reg + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign tx   = shift_reg[0];
    assign busy = busy_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed self-checking bench for uart_tx_cfg: frame formats, FIFO limits, clear and reset.
module tb_uart_tx_cfg;

    localparam int BUFFER = 8;

    logic        clk;
    logic        rstz;
    logic        tx;
    logic [15:0] prescaler;
    logic [1:0]  data_bits;
    logic [1:0]  parity;
    logic        stop2;
    logic        enable;
    logic        clear;
    logic        full;
    logic        empty;
    logic [15:0] size;
    logic        busy;
    logic [7:0]  dat_i;
    logic        we_i;
    logic        stb_i;
    logic        ack_o;

    int vectors = 0;
    int errors  = 0;

    uart_tx_cfg #(.BUFFER(BUFFER)) dut (
        .clk       (clk),
        .rstz      (rstz),
        .tx        (tx),
        .prescaler (prescaler),
        .data_bits (data_bits),
        .parity    (parity),
        .stop2     (stop2),
        .enable    (enable),
        .clear     (clear),
        .full      (full),
        .empty     (empty),
        .size      (size),
        .busy      (busy),
        .dat_i     (dat_i),
        .we_i      (we_i),
        .stb_i     (stb_i),
        .ack_o     (ack_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Single Wishbone write; returns 1 time unit after the push edge.
    task automatic wb_write(input logic [7:0] d);
        @(posedge clk);
        @(negedge clk);
        dat_i = d;
        stb_i = 1'b1;
        we_i  = 1'b1;
        #1 chk("ack_early", ack_o, 1'b0);
        @(negedge clk);
        chk($sformatf("ack_%02h", d), ack_o, 1'b1);
        @(posedge clk);
        #1;
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    function automatic logic [11:0] f8n1(input logic [7:0] d);
        return {2'b11, 1'b1, d, 1'b0};
    endfunction

    // bits[i] is the i-th bit on the line; every clock of every bit is checked.
    task automatic expect_frame(input logic [11:0] bits, input int n, input int p,
                                input bit strict_start, input int mid_bit);
        int k;
        if (strict_start) begin
            @(negedge clk);
        end else begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (tx !== 1'b0 && k < 500);
            if (tx !== 1'b0) begin
                chk("start_timeout", tx, 1'b0);
                return;
            end
        end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c <= p; c++) begin
                if (i != 0 || c != 0) @(negedge clk);
                if (i == mid_bit && c == 0) begin
                    clear     = 1'b1;
                    data_bits = 2'd0;
                    prescaler = 16'd1;
                end
                if (i == mid_bit && c == 1) clear = 1'b0;
                chk($sformatf("bit%0d_clk%0d", i, c), tx, bits[i]);
                chk($sformatf("busy_bit%0d", i), busy, 1'b1);
            end
        end
        @(negedge clk);
        chk("idle_tx", tx, 1'b1);
        chk("idle_busy", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        prescaler = 16'd3;
        data_bits = 2'd3;
        parity    = 2'd0;
        stop2     = 1'b0;
        enable    = 1'b0;
        clear     = 1'b0;
        dat_i     = 8'h00;
        we_i      = 1'b0;
        stb_i     = 1'b0;
        rstz      = 1'b1;
        #1 rstz   = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_ack", ack_o, 1'b0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_size", size, 16'd0);
        chk("rst_busy", busy, 1'b0);
        rstz = 1'b1;
        repeat (2) @(negedge clk);

        // reads are never acked
        stb_i = 1'b1;
        we_i  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("read_ack", ack_o, 1'b0);
        end
        stb_i = 1'b0;
        chk("read_size", size, 16'd0);

        // 8N1, prescaler 3, 0xA5 with 3-clock ack-to-start latency
        enable = 1'b1;
        wb_write(8'hA5);
        @(negedge clk);
        chk("lat_tx_c2", tx, 1'b1);
        chk("lat_size", size, 16'd1);
        chk("lat_empty_lag", empty, 1'b1);
        @(negedge clk);
        chk("lat_tx_c3", tx, 1'b1);
        chk("lat_busy_c3", busy, 1'b0);
        chk("lat_empty", empty, 1'b0);
        // 0,1,0,1,0,0,1,0,1,1
        expect_frame(12'b0011_0100_1010, 10, 3, 1'b1, -1);

        // 7E2, prescaler 1, 0xC1: 0,1,0,0,0,0,0,1,0,1,1
        prescaler = 16'd1;
        data_bits = 2'd2;
        parity    = 2'd1;
        stop2     = 1'b1;
        wb_write(8'hC1);
        expect_frame(12'b0110_1000_0010, 11, 1, 1'b0, -1);

        // 5O1, prescaler 0, 0x1F then 0x00 with a single idle clock between
        enable    = 1'b0;
        prescaler = 16'd0;
        data_bits = 2'd0;
        parity    = 2'd2;
        stop2     = 1'b0;
        wb_write(8'h1F);
        wb_write(8'h00);
        enable = 1'b1;
        expect_frame(12'b0000_1011_1110, 8, 0, 1'b0, -1);
        expect_frame(12'b0000_1100_0000, 8, 0, 1'b1, -1);

        // fill past capacity with transmission held off
        enable    = 1'b0;
        data_bits = 2'd3;
        parity    = 2'd0;
        for (int i = 0; i < BUFFER + 2; i++) wb_write(8'h10 + 8'(i));
        repeat (2) @(negedge clk);
        chk("fill_size", size, 16'(BUFFER));
        chk("fill_full", full, 1'b1);
        chk("fill_empty", empty, 1'b0);
        chk("fill_tx", tx, 1'b1);
        enable = 1'b1;
        for (int i = 0; i < BUFFER; i++)
            expect_frame(f8n1(8'h10 + 8'(i)), 10, 0, i != 0, -1);
        repeat (2) @(negedge clk);
        chk("drain_empty", empty, 1'b1);
        chk("drain_size", size, 16'd0);
        chk("drain_tx", tx, 1'b1);

        // mid-frame clear and config change
        enable    = 1'b0;
        prescaler = 16'd3;
        data_bits = 2'd3;
        wb_write(8'h3C);
        wb_write(8'h81);
        enable = 1'b1;
        expect_frame(f8n1(8'h3C), 10, 3, 1'b0, 3);
        chk("clr_size", size, 16'd0);
        chk("clr_empty", empty, 1'b1);
        repeat (12) @(negedge clk);
        chk("clr_tx_quiet", tx, 1'b1);
        chk("clr_busy_quiet", busy, 1'b0);
        // 5N1 prescaler 1, 0x5A: 0,0,1,0,1,1,1
        wb_write(8'h5A);
        expect_frame(12'b0000_0111_0100, 7, 1, 1'b0, -1);

        // asynchronous reset during the data bits
        enable    = 1'b0;
        prescaler = 16'd3;
        data_bits = 2'd3;
        wb_write(8'h00);
        wb_write(8'h00);
        enable = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx !== 1'b0 && k < 500);
        chk("rst_frame_start", tx, 1'b0);
        repeat (12) @(negedge clk);
        chk("rst_pre_tx", tx, 1'b0);
        chk("rst_pre_busy", busy, 1'b1);
        rstz = 1'b0;
        #1;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_size", size, 16'd0);
        repeat (2) @(negedge clk);
        rstz = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            chk("post_rst_tx", tx, 1'b1);
        end
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_empty", empty, 1'b1);
        chk("post_rst_size", size, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
